// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared widths and lane/bundle types for the writeback stage
package wb_stage_pkg;
    localparam int WB_WIDTH = 32;
    localparam int WB_RS = 5;
    typedef struct packed {
        logic valid;
        logic we;
        logic [WB_RS-1:0] rd;
        logic [WB_WIDTH-1:0] result;
    } wb_lane_t;
    typedef wb_lane_t [1:0] wb_bundle_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: in-order DEPTH-entry bundle queue with wrapping pointers
module wb_fifo
    import wb_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  wb_bundle_t din,
    output wb_bundle_t dout,
    output logic       empty,
    output logic       full
);
    localparam int AW = $clog2(DEPTH);
    wb_bundle_t mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        empty = cnt_q == '0;
        full = cnt_q == (AW+1)'(DEPTH);
        dout = mem_q[rptr_q];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q <= '0;
        end else begin
            wptr_q <= push ? wptr_q + 1'b1 : wptr_q;
            rptr_q <= pop ? rptr_q + 1'b1 : rptr_q;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= din;
    end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: queued writeback with x0/WAW filtering; WB_RETIRE_CNT_EN adds the instret counter
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int WIDTH = WB_WIDTH,
    parameter int RS = WB_RS,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            ex_valid,
    input  logic [1:0]            ex_we,
    input  logic [1:0][RS-1:0]    ex_rd,
    input  logic [1:0][WIDTH-1:0] ex_result,
    output logic                  ex_ready,
    input  logic                  hold,
    output logic [1:0][RS-1:0]    rd,
    output logic [1:0][WIDTH-1:0] wd,
    output logic [1:0]            write_en,
    output logic [1:0]            byp_valid
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0]           instret
`endif
);
    wb_bundle_t din, head;
    logic empty, full, push, pop;
    logic [1:0] wr;
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            din[i] = '{valid: ex_valid[i], we: ex_we[i], rd: ex_rd[i], result: ex_result[i]};
            wr[i] = pop & head[i].valid & head[i].we & (|head[i].rd);
            rd[i] = empty ? '0 : head[i].rd;
            wd[i] = empty ? '0 : head[i].result;
        end
        ex_ready = ~full;
        push = (|ex_valid) & ~full;
        pop = ~empty & ~hold;
        // younger lane 1 wins a same-register conflict
        write_en = {wr[1], wr[0] & ~(wr[1] & (head[0].rd == head[1].rd))};
        byp_valid = write_en;
    end
    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .pop(pop),
        .din(din), .dout(head), .empty(empty), .full(full)
    );
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] instret_q, instret_d;
    always_comb instret_d = instret_q + (pop ? 64'(head[0].valid) + 64'(head[1].valid) : 64'd0);
    always_ff @(posedge clk) begin
        instret_q <= rst ? 64'd0 : instret_d;
    end
    assign instret = instret_q;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: randomized and directed checks of wb_stage against a queue-based model
module tb_wb_stage;
    typedef struct packed {
        logic [1:0] v;
        logic [1:0] we;
        logic [1:0][4:0] rd;
        logic [1:0][31:0] r;
    } bun_t;
    logic clk, rst, hold, ex_ready;
    logic [1:0] ex_valid, ex_we, write_en, byp_valid;
    logic [1:0][4:0] ex_rd, rd;
    logic [1:0][31:0] ex_result, wd;
    logic [63:0] instret;
    int total = 0, bad = 0;
    bun_t mq[$];
    logic [63:0] mcnt;
    wb_stage dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_we(ex_we), .ex_rd(ex_rd),
        .ex_result(ex_result), .ex_ready(ex_ready), .hold(hold), .rd(rd), .wd(wd),
        .write_en(write_en), .byp_valid(byp_valid)
`ifdef WB_RETIRE_CNT_EN
        , .instret(instret)
`endif
    );
`ifndef WB_RETIRE_CNT_EN
    assign instret = 64'd0;
`endif
    initial clk = 0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic bun_t mk(logic [1:0] v, logic [1:0] we, logic [4:0] r0, logic [4:0] r1, logic [31:0] d0, logic [31:0] d1);
        bun_t b;
        b.v = v; b.we = we; b.rd[0] = r0; b.rd[1] = r1; b.r[0] = d0; b.r[1] = d1;
        return b;
    endfunction
    task automatic model_check(input logic h);
        logic [1:0] ew = 2'b00;
        bun_t hd;
        if (mq.size() > 0) begin
            hd = mq[0];
            if (!h)
                for (int i = 0; i < 2; i++) ew[i] = hd.v[i] && hd.we[i] && hd.rd[i] != 0;
            if (ew == 2'b11 && hd.rd[0] == hd.rd[1]) ew[0] = 1'b0;
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("rd%0d", i), 64'(rd[i]), 64'(hd.rd[i]));
                chk($sformatf("wd%0d", i), 64'(wd[i]), 64'(hd.r[i]));
            end
        end
        chk("ex_ready", 64'(ex_ready), 64'(mq.size() < 2));
        chk("write_en", 64'(write_en), 64'(ew));
        chk("byp_valid", 64'(byp_valid), 64'(ew));
`ifdef WB_RETIRE_CNT_EN
        chk("instret", instret, mcnt);
`endif
    endtask
    task automatic cyc(input logic r, input logic h, input bun_t b);
        int sz;
        rst = r; hold = h;
        ex_valid = b.v; ex_we = b.we; ex_rd = b.rd; ex_result = b.r;
        #1;
        model_check(h);
        sz = mq.size();
        @(posedge clk);
        if (r) begin
            mq.delete();
            mcnt = 0;
        end else begin
            if (sz > 0 && !h) begin
                mcnt += 64'(mq[0].v[0]) + 64'(mq[0].v[1]);
                void'(mq.pop_front());
            end
            if (b.v != 0 && sz < 2) mq.push_back(b);
        end
        @(negedge clk);
    endtask
    task automatic look(input logic h);
        rst = 0; hold = h; ex_valid = 0;
        #1;
    endtask
    initial begin
        bun_t b1, b2, b3, b;
        rst = 1; hold = 0; ex_valid = 0; ex_we = 0; ex_rd = 0; ex_result = 0;
        mcnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        look(0);
        chk("rst_write_en", 64'(write_en), 64'd0);
        chk("rst_ready", 64'(ex_ready), 64'd1);
        chk("rst_rd_wd", 64'({rd, wd[0]}), 64'd0);
        chk("rst_instret", instret, 64'd0);
        cyc(0, 0, mk(2'b11, 2'b11, 5'd5, 5'd0, 32'hDEADBEEF, 32'h1234));
        look(0);
        chk("x0_write_en", 64'(write_en), 64'b01);
        chk("x0_rd0", 64'(rd[0]), 64'd5);
        chk("x0_wd0", 64'(wd[0]), 64'hDEADBEEF);
        cyc(0, 0, '0);
        cyc(0, 0, mk(2'b11, 2'b11, 5'd7, 5'd7, 32'h11, 32'h22));
        look(0);
        chk("waw_write_en", 64'(write_en), 64'b10);
        chk("waw_wd1", 64'(wd[1]), 64'h22);
        cyc(0, 0, '0);
        b1 = mk(2'b11, 2'b11, 5'd1, 5'd2, 32'hA1, 32'hA2);
        b2 = mk(2'b11, 2'b11, 5'd3, 5'd4, 32'hB1, 32'hB2);
        b3 = mk(2'b10, 2'b10, 5'd0, 5'd6, 32'hC1, 32'hC2);
        cyc(0, 1, b1);
        cyc(0, 1, b2);
        look(1);
        chk("bp_ready", 64'(ex_ready), 64'd0);
        cyc(0, 1, b3);
        cyc(0, 0, b3);
        cyc(0, 0, b3);
        look(0);
        chk("bp_third_we", 64'(write_en), 64'b10);
        chk("bp_third_wd1", 64'(wd[1]), 64'hC2);
        cyc(0, 0, '0);
        cyc(0, 1, b1);
        cyc(0, 1, b2);
        cyc(1, 0, b3);
        look(0);
        chk("midrst_write_en", 64'(write_en), 64'd0);
        chk("midrst_ready", 64'(ex_ready), 64'd1);
        repeat (3) cyc(0, 0, '0);
        cyc(1, 0, '0);
        cyc(0, 0, mk(2'b11, 2'b11, 5'd1, 5'd2, 32'd1, 32'd2));
        cyc(0, 0, mk(2'b01, 2'b01, 5'd3, 5'd4, 32'd3, 32'd4));
        cyc(0, 0, mk(2'b11, 2'b00, 5'd5, 5'd6, 32'd5, 32'd6));
        cyc(0, 0, mk(2'b11, 2'b11, 5'd8, 5'd9, 32'd7, 32'd8));
        repeat (3) cyc(0, 0, '0);
`ifdef WB_RETIRE_CNT_EN
        look(0);
        chk("instret7", instret, 64'd7);
`endif
        for (int n = 0; n < 500; n++) begin
            b = mk(2'($urandom), 2'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom);
            cyc($urandom_range(0, 31) == 0, $urandom_range(0, 3) == 0, b);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
